// File: rtl/addsub_serial_pkg.sv
// Shared constants, state encoding and slice-count helper for the serial
// nibble-wide add/sub controller.
package addsub_serial_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/addsub_serial_ctrl_if.sv
// Requester-facing command/result bundle of the serial add/sub controller.
interface addsub_serial_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/addsub4_slice.sv
// Combinational 4-bit add/sub slice: s = a + (b ^ {4{sub}}) + cin.
module addsub4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b ^ {4{sub}}} + {4'b0000, cin};
    assign s    = sum[3:0];
    assign cout = sum[4];
endmodule

// File: rtl/addsub_serial_ctrl.sv
// Serial WIDTH-bit add/sub: one nibble per cycle through a single shared
// slice, LS nibble first, with a registered inter-slice carry.
module addsub_serial_ctrl
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    addsub_serial_ctrl_if.slave bus
);
    localparam int N     = slice_count(WIDTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sub_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] result_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             cout_reg;
    logic             overflow_reg;
    logic             zero_reg;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic [WIDTH-1:0]   result_next;
    logic               accept;
    logic               last_slice;
    logic               overflow_next;

    // Requests are only honoured when idle or in the done cycle.
    assign accept     = bus.start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign last_slice = (state_reg == S_RUN) && (idx_reg == IDX_LAST);

    addsub4_slice u_slice (
        .a    (a_reg[int'(idx_reg) * SLICE_W +: SLICE_W]),
        .b    (b_reg[int'(idx_reg) * SLICE_W +: SLICE_W]),
        .sub  (sub_reg),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        result_next = result_reg;
        result_next[int'(idx_reg) * SLICE_W +: SLICE_W] = slice_s;
    end

    // Signed overflow: operands (with effective b) agree in sign, result differs.
    assign overflow_next = (a_reg[WIDTH-1] == (b_reg[WIDTH-1] ^ sub_reg)) &&
                           (result_next[WIDTH-1] != a_reg[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            sub_reg      <= 1'b0;
            carry_reg    <= 1'b0;
            idx_reg      <= '0;
            result_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        sub_reg   <= bus.sub;
                        carry_reg <= bus.sub;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_RUN;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_RUN: begin
                    result_reg <= result_next;
                    carry_reg  <= slice_cout;
                    idx_reg    <= idx_reg + 1'b1;
                    if (last_slice) begin
                        idx_reg      <= '0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        cout_reg     <= slice_cout;
                        overflow_reg <= overflow_next;
                        zero_reg     <= ~|result_next;
                        state_reg    <= S_DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.result   = result_reg;
    assign bus.cout     = cout_reg;
    assign bus.overflow = overflow_reg;
    assign bus.zero     = zero_reg;
endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Randomized self-checking bench for addsub_serial_ctrl against an
// arithmetic reference model.
module tb_addsub_serial_ctrl;
    localparam int WIDTH = 16;
    localparam int N     = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    addsub_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    addsub_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the full operands.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] r, output logic c, output logic ov, output logic z);
        int sa, sb, sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            r  = a + b;
            c  = (int'(a) + int'(b)) > 65535;
            sr = sa + sb;
        end
        ov = (sr > 32767) || (sr < -32768);
        z  = (r == 16'h0000);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_result"},   32'(bus.result),   32'd0);
        check({tag, "_cout"},     32'(bus.cout),     32'd0);
        check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
        check({tag, "_zero"},     32'(bus.zero),     32'd0);
    endtask

    // Present a request now; it is sampled on the next rising edge. Inputs are
    // scrambled afterwards so any late sampling of a/b/sub shows up.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.sub   = 1'($urandom);
    endtask

    task automatic wait_done(input logic [15:0] a, input logic [15:0] b, input logic s,
                             input bit glitch);
        logic [15:0] er;
        logic        ec, eov, ez;
        int          seen;
        model(a, b, s, er, ec, eov, ez);
        seen = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = k;
                break;
            end
            check("busy_run", 32'(bus.busy), 32'd1);
            if (glitch && k == 1) begin
                bus.start = 1'b1;
                bus.a     = 16'hAAAA;
                bus.b     = 16'h5555;
                bus.sub   = 1'b1;
            end
            if (glitch && k == 2) bus.start = 1'b0;
        end
        if (seen == 0) begin
            check("done_seen", 32'(bus.done), 32'd1);
        end else begin
            check("latency",   32'(seen - 1),      32'(N));
            check("result",    32'(bus.result),    32'(er));
            check("cout",      32'(bus.cout),      32'(ec));
            check("overflow",  32'(bus.overflow),  32'(eov));
            check("zero",      32'(bus.zero),      32'(ez));
            check("busy_done", 32'(bus.busy),      32'd0);
        end
        $display("op a=%04h b=%04h sub=%0d -> result=%04h cout=%0d ovf=%0d zero=%0d (exp %04h %0d %0d %0d)",
                 a, b, s, bus.result, bus.cout, bus.overflow, bus.zero, er, ec, eov, ez);
    endtask

    logic [15:0] dir_a [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0000};
    logic [15:0] dir_b [6] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000};
    logic        dir_s [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rs;

        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.sub   = 1'($urandom);
        repeat (3) @(negedge clk);
        check_zero("reset");
        bus.start = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_done", 32'(bus.done), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            issue(dir_a[i], dir_b[i], dir_s[i]);
            wait_done(dir_a[i], dir_b[i], dir_s[i], 1'b0);
            @(negedge clk);
            check("done_pulse", 32'(bus.done), 32'd0);
        end

        // A start raised while RUN must be ignored.
        issue(16'h0100, 16'h0001, 1'b0);
        wait_done(16'h0100, 16'h0001, 1'b0, 1'b1);

        // Back-to-back: new request in the done cycle.
        issue(16'h0003, 16'h0001, 1'b1);
        wait_done(16'h0003, 16'h0001, 1'b1, 1'b0);

        // Abort two cycles into RUN.
        issue(16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_done", 32'(bus.done), 32'd0);
        issue(16'h00FF, 16'h0001, 1'b0);
        wait_done(16'h00FF, 16'h0001, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                check("done_pulse", 32'(bus.done), 32'd0);
            end
            issue(ra, rb, rs);
            wait_done(ra, rb, rs, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
